// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: switch-to-LED controller for the board I/O layer.
// Each channel synchronises and debounces its slide switch, emits a one-cycle
// rising-edge pulse, and drives its LED in one of four modes selected by MODE:
//   00 direct, 01 toggle-latch, 10 blink, 11 invert.
// Optional feature: define LED_DIM_EN to add a 16-step PWM dimmer (DIM_DUTY/16)
// on the final LED drive. Without it, LED is the mode output directly.
module sw_led_ctrl #(
  parameter int N               = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
`ifdef LED_DIM_EN
  parameter int DIM_DUTY        = 4,
`endif
  parameter int BLINK_DIV       = 50000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] SW,
  input  logic [1:0]   MODE,
  output logic [N-1:0] LED,
  output logic [N-1:0] SW_STABLE,
  output logic [N-1:0] SW_RISE
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int BKW = $clog2(BLINK_DIV);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_DIV - 1);

  logic [N-1:0]   sw_s1, sw_s2;
  logic [1:0]     mode_s1, mode_s2;
  logic [DBW-1:0] db_cnt [N];
  logic [N-1:0]   stable_q;
  logic [N-1:0]   rise_q;
  logic [N-1:0]   toggle_q;
  logic [BKW-1:0] blink_cnt;
  logic           blink_phase;
  logic [N-1:0]   mode_led;
  logic [N-1:0]   led_next;

  // Two-flop synchronisers for the raw switches and the mode select
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      mode_s1 <= '0;
      mode_s2 <= '0;
    end else begin
      sw_s1   <= SW;
      sw_s2   <= sw_s1;
      mode_s1 <= MODE;
      mode_s2 <= mode_s1;
    end
  end

  // Per-channel debounce: a disagreement must persist for DEBOUNCE_CYCLES
  // consecutive cycles; any agreement restarts the count. The rise pulse is
  // raised on the same edge the stable state first becomes 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) db_cnt[i] <= '0;
      stable_q <= '0;
      rise_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        rise_q[i] <= 1'b0;
        if (sw_s2[i] == stable_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable_q[i] <= sw_s2[i];
          rise_q[i]   <= sw_s2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Toggle latches flip on a rise pulse only while the synced mode is 01;
  // they hold across every other mode so the latched state survives mode hops
  always_ff @(posedge CLK) begin
    if (RST) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ (rise_q & {N{mode_s2 == 2'b01}});
    end
  end

  // Free-running blink divider shared by all channels; phase flips on wrap
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // LED source selected by the synced mode
  always_comb begin
    mode_led = '0;
    case (mode_s2)
      2'b00:   mode_led = stable_q;
      2'b01:   mode_led = toggle_q;
      2'b10:   mode_led = stable_q & {N{blink_phase}};
      default: mode_led = ~stable_q;
    endcase
  end

`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt;

  // 16-step PWM counter; LED is enabled for the first DIM_DUTY steps
  always_ff @(posedge CLK) begin
    if (RST) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 4'd1;
  end

  // Gate the mode output with the PWM duty window
  always_comb begin
    led_next = mode_led & {N{pwm_cnt < 4'(DIM_DUTY)}};
  end
`else
  // Mode output drives the LED register directly
  always_comb begin
    led_next = mode_led;
  end
`endif

  // Registered LED drive so a mode change yields at most one clean update
  always_ff @(posedge CLK) begin
    if (RST) LED <= '0;
    else     LED <= led_next;
  end

  assign SW_STABLE = stable_q;
  assign SW_RISE   = rise_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Bench for sw_led_ctrl with N=4, DEBOUNCE_CYCLES=4, BLINK_DIV=3.
// Inputs change 1 time unit after a rising edge ("edge 0"); outputs are
// sampled at the same point after later edges.
module tb_sw_led_ctrl;
  localparam int N  = 4;
  localparam int DC = 4;
  localparam int BD = 3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] SW = '0;
  logic [1:0]   MODE = 2'b00;
  logic [N-1:0] LED, SW_STABLE, SW_RISE;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_q[$];

  sw_led_ctrl #(
    .N(N),
    .DEBOUNCE_CYCLES(DC),
    .BLINK_DIV(BD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .SW(SW),
    .MODE(MODE),
    .LED(LED),
    .SW_STABLE(SW_STABLE),
    .SW_RISE(SW_RISE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [N-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [N-1:0] obs);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // drive a switch pattern and let it fully settle
  task automatic settle_sw(input logic [N-1:0] v);
    SW = v;
    repeat (10) tick();
  endtask

`ifdef LED_DIM_EN
  initial begin
    int on_cnt;
    apply_reset();
    MODE = 2'b00;
    settle_sw(4'b0001);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      on_cnt += int'(LED[0]);
      tick();
    end
    check("dim_duty", 32'(on_cnt), 32'd4);
    check("dim_stable", 32'(SW_STABLE), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
`else
  initial begin
    int n;
    int rises;
    logic [N-1:0] v;

    // reset state
    apply_reset();
    check("rst_led", 32'(LED), 32'h0);
    check("rst_stable", 32'(SW_STABLE), 32'h0);
    check("rst_rise", 32'(SW_RISE), 32'h0);

    // direct mode latency: stable at edge 6, LED at edge 7, one rise pulse
    SW = 4'b0101;
    push_exp(4'b0101);  // SW_STABLE at edge 6
    push_exp(4'b0101);  // SW_RISE at edge 6
    push_exp(4'b0000);  // LED at edge 6
    push_exp(4'b0101);  // LED at edge 7
    push_exp(4'b0000);  // SW_RISE at edge 7
    repeat (5) tick();
    check("dir_stable_early", 32'(SW_STABLE), 32'h0);
    check("dir_rise_early", 32'(SW_RISE), 32'h0);
    tick();
    pop_check("dir_stable", SW_STABLE);
    pop_check("dir_rise", SW_RISE);
    pop_check("dir_led_early", LED);
    tick();
    pop_check("dir_led", LED);
    pop_check("dir_rise_once", SW_RISE);

    // falling edge gives no pulse
    SW = 4'b0000;
    rises = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (SW_RISE != '0) rises++;
    end
    check("fall_no_rise", 32'(rises), 32'd0);
    check("fall_stable", 32'(SW_STABLE), 32'h0);
    check("fall_led", 32'(LED), 32'h0);

    // bounce on SW[0]: 1,0,1 then hold; last change at edge 2 -> stable at edge 8
    SW = 4'b0001;
    tick();
    SW = 4'b0000;
    tick();
    SW = 4'b0001;
    n = 2;
    rises = 0;
    while (SW_STABLE[0] == 1'b0 && n < 40) begin
      tick();
      n++;
      rises += int'(SW_RISE[0]);
    end
    check("bounce_latency", 32'(n), 32'd8);
    for (int k = 0; k < 5; k++) begin
      tick();
      rises += int'(SW_RISE[0]);
    end
    check("bounce_one_rise", 32'(rises), 32'd1);
    settle_sw(4'b0000);

    // toggle mode on SW[2]
    MODE = 2'b01;
    repeat (3) tick();
    push_exp(4'b0000);
    pop_check("tog_init", LED);
    push_exp(4'b0100);
    settle_sw(4'b0100);
    pop_check("tog_first", LED);
    push_exp(4'b0100);
    settle_sw(4'b0000);
    pop_check("tog_release", LED);
    push_exp(4'b0000);
    settle_sw(4'b0100);
    pop_check("tog_second", LED);
    settle_sw(4'b0000);
    push_exp(4'b0100);
    settle_sw(4'b0100);
    pop_check("tog_third", LED);
    settle_sw(4'b0000);
    MODE = 2'b00;
    repeat (5) tick();
    push_exp(4'b0000);
    pop_check("tog_mode00", LED);
    MODE = 2'b01;
    repeat (5) tick();
    push_exp(4'b0100);
    pop_check("tog_preserved", LED);

    // invert mode, with 3-edge mode latency
    MODE = 2'b00;
    repeat (5) tick();
    settle_sw(4'b1010);
    check("inv_pre_led", 32'(LED), 32'hA);
    MODE = 2'b11;
    push_exp(4'b1010);
    push_exp(4'b0101);
    repeat (2) tick();
    pop_check("inv_mode_lat", LED);
    tick();
    pop_check("inv_led", LED);

    // blink mode: LED alternates 0000/1111, each level held 3 cycles
    MODE = 2'b10;
    settle_sw(4'b1111);
    v = LED;
    n = 0;
    while (LED == v && n < 10) begin
      tick();
      n++;
    end
    check("blink_edge_found", 32'(LED != v), 32'd1);
    v = LED;
    check("blink_level", 32'((v == 4'h0) || (v == 4'hF)), 32'd1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < BD; k++) begin
        push_exp(v);
        pop_check("blink_run", LED);
        tick();
      end
      v = ~v;
    end

    // reset mid-debounce with toggle latch [2] set
    MODE = 2'b01;
    settle_sw(4'b0000);
    check("pre_rst_latch", 32'(LED), 32'h4);
    SW = 4'b0011;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_led", 32'(LED), 32'h0);
    check("mid_rst_stable", 32'(SW_STABLE), 32'h0);
    check("mid_rst_rise", 32'(SW_RISE), 32'h0);
    repeat (5) tick();
    check("post_rst_stable_early", 32'(SW_STABLE), 32'h0);
    tick();
    check("post_rst_stable", 32'(SW_STABLE), 32'h3);
    repeat (4) tick();
    check("post_rst_latch", 32'(LED), 32'h3);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
`endif

endmodule
